// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle drawing path.
//   state_t        : controller states of rect_draw_engine
//   DEF_SCREEN_W/H : default visible screen size in pixels
//   BLACK / WHITE  : 3-bit palette constants used by the renderer and reset
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'd0;
  localparam logic [2:0] WHITE = 3'd7;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major scan position counter for the rectangle rasteriser.
//   clk, reset : clock and synchronous active-high reset
//   clear_i    : restart the scan at (0,0) (a new command was accepted)
//   advance_i  : step to the next position (xc fastest)
//   w_i, h_i   : latched rectangle width/height, both non-zero while scanning
//   xc_o, yc_o : current offset inside the rectangle
//   last_o     : current position is the final one (xc=w-1, yc=h-1)
module rect_scan_counter
  import draw_pkg::*;
#(
  parameter int DIM_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] w_i,
  input  logic [DIM_W-1:0] h_i,
  output logic [DIM_W-1:0] xc_o,
  output logic [DIM_W-1:0] yc_o,
  output logic             last_o
);

  logic [DIM_W-1:0] xc_q, xc_d;
  logic [DIM_W-1:0] yc_q, yc_d;
  logic             x_more;
  logic             y_more;

  assign x_more = xc_q < (w_i - DIM_W'(1));
  assign y_more = yc_q < (h_i - DIM_W'(1));

  always_comb begin
    xc_d = xc_q;
    yc_d = yc_q;
    if (clear_i) begin
      xc_d = '0;
      yc_d = '0;
    end else if (advance_i) begin
      if (x_more) begin
        xc_d = xc_q + DIM_W'(1);
      end else begin
        xc_d = '0;
        // Wrapping off the last row returns the counters to (0,0) so the
        // idle outputs sit at the origin of the previous command.
        yc_d = y_more ? (yc_q + DIM_W'(1)) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xc_q <= '0;
      yc_q <= '0;
    end else begin
      xc_q <= xc_d;
      yc_q <= yc_d;
    end
  end

  assign xc_o   = xc_q;
  assign yc_o   = yc_q;
  assign last_o = !x_more && !y_more;

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser between the game renderer and the VGA adapter.
// One command (origin, size, colour, outline flag) is accepted per start
// strobe in IDLE; pixels are then streamed one per accepted handshake.
//   clk, reset            : clock and synchronous active-high reset
//   start                 : command strobe, only looked at in IDLE
//   x_in, y_in            : rectangle origin
//   width, height         : rectangle size; either one zero means no pixels
//   c_in                  : fill colour
//   outline               : 1 = border pixels only, 0 = solid fill
//   pix_ready             : VGA adapter takes the presented pixel
//   x_out, y_out, c_out   : presented pixel
//   plot                  : presented pixel is valid
//   busy                  : command in progress (DRAW or FIN)
//   done                  : one-cycle completion pulse (FIN)
module rect_draw_engine
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int DIM_W    = 5,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  input  logic [COLOR_W-1:0] c_in,
  input  logic               outline,
  input  logic               pix_ready,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] c_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  // The absolute position carries one extra bit so origin+offset beyond
  // the coordinate range lands above the screen limit instead of wrapping.
  localparam int AXW = X_W + 1;
  localparam int AYW = Y_W + 1;
  localparam logic [AXW-1:0] SCR_W_L = AXW'(SCREEN_W);
  localparam logic [AYW-1:0] SCR_H_L = AYW'(SCREEN_H);

  state_t               state_q, state_d;
  logic [X_W-1:0]       x0_q;
  logic [Y_W-1:0]       y0_q;
  logic [DIM_W-1:0]     w_q;
  logic [DIM_W-1:0]     h_q;
  logic [COLOR_W-1:0]   c_q;
  logic                 outline_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DIM_W-1:0]     xc;
  logic [DIM_W-1:0]     yc;
  logic                 last_pos;

  logic                 accept;
  logic                 advance;
  logic                 in_screen;
  logic                 on_edge;
  logic                 visible;
  logic [AXW-1:0]       ax;
  logic [AYW-1:0]       ay;

  assign accept = (state_q == IDLE) && start;

  rect_scan_counter #(
    .DIM_W(DIM_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (accept),
    .advance_i(advance),
    .w_i      (w_q),
    .h_i      (h_q),
    .xc_o     (xc),
    .yc_o     (yc),
    .last_o   (last_pos)
  );

  assign ax = AXW'(x0_q) + AXW'(xc);
  assign ay = AYW'(y0_q) + AYW'(yc);

  assign in_screen = (ax < SCR_W_L) && (ay < SCR_H_L);
  assign on_edge   = (xc == '0) || (xc == (w_q - DIM_W'(1))) ||
                     (yc == '0) || (yc == (h_q - DIM_W'(1)));
  assign visible   = in_screen && (!outline_q || on_edge);

  // Outputs depend only on registered state, so while the adapter stalls
  // (plot high, pix_ready low) nothing moves and the pixel holds stable.
  // Skipped positions advance every cycle without a handshake.
  assign plot    = (state_q == DRAW) && visible;
  assign advance = (state_q == DRAW) && (!plot || pix_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ((width == '0) || (height == '0)) ? FIN : DRAW;
        end
      end
      DRAW: begin
        if (advance && last_pos) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      c_q       <= COLOR_W'(BLACK);
      outline_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FIN);
      if (accept) begin
        x0_q      <= x_in;
        y0_q      <= y_in;
        w_q       <= width;
        h_q       <= height;
        c_q       <= c_in;
        outline_q <= outline;
      end
    end
  end

  assign x_out = ax[X_W-1:0];
  assign y_out = ay[Y_W-1:0];
  assign c_out = c_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Scoreboard bench for rect_draw_engine: stimulus pushes expected pixels,
// a negedge monitor pops and compares every accepted pixel.
module tb_rect_draw_engine;
  import draw_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [4:0] width = '0;
  logic [4:0] height = '0;
  logic [2:0] c_in = '0;
  logic       outline = 1'b0;
  logic       pix_ready = 1'b1;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] c_out;
  logic       plot;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  int stall_cnt = 0;

  rect_draw_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .width    (width),
    .height   (height),
    .c_in     (c_in),
    .outline  (outline),
    .pix_ready(pix_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .c_out    (c_out),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int pk(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic exp_px(input int x, input int y, input int c);
    exp_q.push_back(pk(x, y, c));
  endtask

  // Monitor: pixel scoreboard plus hold-stability during stalls.
  logic prev_stall = 1'b0;
  int   prev_pix = 0;
  always @(negedge clk) begin
    int cur;
    int e;
    cur = pk(int'(x_out), int'(y_out), int'(c_out));
    if (prev_stall) begin
      check("hold_pixel", cur, prev_pix);
      check("hold_plot", int'(plot), 1);
      stall_cnt++;
    end
    if (plot && pix_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", cur, -1);
      end else begin
        e = exp_q.pop_front();
        check("pixel", cur, e);
      end
    end
    prev_stall = plot && !pix_ready && !reset;
    prev_pix = cur;
  end

  task automatic issue(input int x, input int y, input int w, input int h,
                       input int c, input bit ol);
    @(posedge clk); #1;
    start   = 1'b1;
    x_in    = 8'(x);
    y_in    = 7'(y);
    width   = 5'(w);
    height  = 5'(h);
    c_in    = 3'(c);
    outline = ol;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Called just after the start edge; counts DRAW cycles and done pulses.
  task automatic wait_done(input string nm, input int exp_draw, input bit exp_first);
    int draw_cyc = 0;
    int dones = 0;
    bit fin = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) check({nm, "_first_plot"}, int'(plot), int'(exp_first));
      if (done) dones++;
      else if (busy) draw_cyc++;
      else if (dones > 0) begin
        fin = 1'b1;
        break;
      end
    end
    check({nm, "_finished"}, int'(fin), 1);
    check({nm, "_draw_cycles"}, draw_cyc, exp_draw);
    check({nm, "_done_pulses"}, dones, 1);
    check({nm, "_busy_after"}, int'(busy), 0);
    check({nm, "_pixels_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_c", int'(c_out), 0);

    // Solid fill
    exp_px(10, 20, 5); exp_px(11, 20, 5); exp_px(12, 20, 5);
    exp_px(10, 21, 5); exp_px(11, 21, 5); exp_px(12, 21, 5);
    issue(10, 20, 3, 2, 5, 1'b0);
    wait_done("solid", 6, 1'b1);

    // Back-pressure on the second pixel for 3 cycles
    exp_px(10, 20, 5); exp_px(11, 20, 5); exp_px(12, 20, 5);
    exp_px(10, 21, 5); exp_px(11, 21, 5); exp_px(12, 21, 5);
    stall_cnt = 0;
    issue(10, 20, 3, 2, 5, 1'b0);
    fork
      wait_done("bp", 9, 1'b1);
      begin
        @(posedge clk); #1 pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 pix_ready = 1'b1;
      end
    join
    check("bp_stall_cycles", stall_cnt, 3);

    // Outline 4x3 at origin
    exp_px(0, 0, 7); exp_px(1, 0, 7); exp_px(2, 0, 7); exp_px(3, 0, 7);
    exp_px(0, 1, 7); exp_px(3, 1, 7);
    exp_px(0, 2, 7); exp_px(1, 2, 7); exp_px(2, 2, 7); exp_px(3, 2, 7);
    issue(0, 0, 4, 3, int'(WHITE), 1'b1);
    wait_done("outline", 12, 1'b1);

    // Partial clip at the bottom-right corner
    exp_px(158, 118, 3); exp_px(159, 118, 3);
    exp_px(158, 119, 3); exp_px(159, 119, 3);
    issue(158, 118, 4, 4, 3, 1'b0);
    wait_done("clip", 16, 1'b1);

    // Fully clipped
    issue(200, 10, 2, 2, 6, 1'b0);
    wait_done("clip_all", 4, 1'b0);

    // Zero width
    issue(5, 5, 0, 3, 1, 1'b0);
    wait_done("zero_w", 0, 1'b0);

    // start while busy is ignored
    exp_px(10, 20, 5); exp_px(11, 20, 5); exp_px(12, 20, 5);
    exp_px(10, 21, 5); exp_px(11, 21, 5); exp_px(12, 21, 5);
    issue(10, 20, 3, 2, 5, 1'b0);
    fork
      wait_done("busy_start", 6, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; x_in = 8'd50; y_in = 7'd50;
        width = 5'd1; height = 5'd1; c_in = 3'd1;
        @(posedge clk); #1 start = 1'b0;
      end
    join

    // Reset after two pixels of a 5x5 fill
    exp_px(30, 40, 2); exp_px(31, 40, 2);
    issue(30, 40, 5, 5, 2, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_plot", int'(plot), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_pixels_left", exp_q.size(), 0);
    d = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) d++;
    end
    check("mid_rst_no_done", d, 0);

    // Command after reset
    exp_px(100, 50, 7); exp_px(101, 50, 7);
    exp_px(100, 51, 7); exp_px(101, 51, 7);
    issue(100, 50, 2, 2, int'(WHITE), 1'b0);
    wait_done("after_rst", 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
